// File: rtl/fetch_unit.sv
// Instruction fetch: turns fetch_pc into in-order memory requests, buffers returned words
// in a small queue and hands {instr, pc, pc+4} to decode; redirects discard wrong-path work.
module fetch_unit #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PC_WIDTH-1:0]    fetch_pc,
    input  logic                   redirect,
    output logic                   pc_en,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [PC_WIDTH-1:0]    imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
    output logic                   id_valid,
    input  logic                   id_ready,
    output logic [INSTR_WIDTH-1:0] id_instr,
    output logic [PC_WIDTH-1:0]    id_pc,
    output logic [PC_WIDTH-1:0]    id_pc_plus4,
    output logic                   id_fault
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    // Handshakes: a transfer happens in any cycle where valid and ready are both high;
    // valid never depends on ready of the same channel except through the decode pop credit.
    logic                   run;
    logic [PC_WIDTH-1:0]    tag_mem [DEPTH];
    logic [PW-1:0]          tag_wptr, tag_rptr;
    logic [INSTR_WIDTH-1:0] q_instr [DEPTH];
    logic [PC_WIDTH-1:0]    q_pc    [DEPTH];
    logic [DEPTH-1:0]       q_fault;
    logic [PW-1:0]          q_head, q_tail;
    logic [CW-1:0]          q_count, outstanding, drop_cnt;

    logic          aligned, q_pop, credit, issue, insert, rsp_drop, rsp_keep, q_push;
    logic [CW:0]   in_use;

    assign aligned  = (fetch_pc[1:0] == 2'b00);
    assign id_valid = (q_count != '0) & ~redirect;
    assign q_pop    = id_valid & id_ready;

    // A slot freed by this cycle's decode pop counts as credit, which keeps a
    // one-cycle-latency memory streaming at one fetch per cycle.
    assign in_use = {1'b0, outstanding} + {1'b0, q_count} - (CW + 1)'(q_pop);
    assign credit = (in_use < DEPTH_C);

    assign imem_req_valid = run & credit & aligned & ~redirect;
    assign imem_req_addr  = fetch_pc;
    assign issue          = imem_req_valid & imem_req_ready;
    assign insert         = run & ~aligned & ~redirect & (outstanding == '0) &
                            ({1'b0, q_count} < DEPTH_C);
    assign pc_en          = issue | insert | (redirect & run);

    assign rsp_drop = imem_rsp_valid & (drop_cnt != '0);
    assign rsp_keep = imem_rsp_valid & (drop_cnt == '0) & ~redirect;
    assign q_push   = rsp_keep | insert;

    assign id_instr    = q_instr[q_head];
    assign id_pc       = q_pc[q_head];
    assign id_pc_plus4 = q_pc[q_head] + PC_WIDTH'(4);
    assign id_fault    = q_fault[q_head];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run         <= 1'b0;
            tag_wptr    <= '0;
            tag_rptr    <= '0;
            q_head      <= '0;
            q_tail      <= '0;
            q_count     <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            q_fault     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_mem[i] <= '0;
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
        end else begin
            run <= 1'b1;
            if (redirect) begin
                // Everything still in flight belongs to the wrong path.
                tag_wptr    <= '0;
                tag_rptr    <= '0;
                q_head      <= '0;
                q_tail      <= '0;
                q_count     <= '0;
                outstanding <= outstanding - CW'(imem_rsp_valid);
                drop_cnt    <= outstanding - CW'(imem_rsp_valid);
            end else begin
                if (issue) begin
                    tag_mem[tag_wptr] <= fetch_pc;
                    tag_wptr          <= tag_wptr + 1'b1;
                end
                if (rsp_keep) tag_rptr <= tag_rptr + 1'b1;
                if (rsp_drop) drop_cnt <= drop_cnt - 1'b1;
                outstanding <= outstanding + CW'(issue) - CW'(imem_rsp_valid);
                if (q_push) begin
                    q_instr[q_tail] <= rsp_keep ? imem_rsp_data : '0;
                    q_pc[q_tail]    <= rsp_keep ? tag_mem[tag_rptr] : fetch_pc;
                    q_fault[q_tail] <= ~rsp_keep;
                    q_tail          <= q_tail + 1'b1;
                end
                if (q_pop) q_head <= q_head + 1'b1;
                q_count <= q_count + CW'(q_push) - CW'(q_pop);
            end
        end
    end
endmodule
